mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 11 +
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage.sv | 118 +++++++++++
 tb/tb_mem_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and widths for the memory stage
package mem_stage_pkg;
  localparam int DATA_W          = 16;
  localparam int REG_AW          = 4;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data memory request/acknowledge bus
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: issues loads/stores, stalls until ack or timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              mem_to_reg,
  input  logic              mem_wen,
  input  logic              reg_wen,
  input  logic [REG_AW-1:0] reg_waddr,
  input  logic              jal,
  input  logic [DATA_W-1:0] next_pc,
  mem_stage_if.master       dmem,
  output logic              stall,
  output logic              wb_wen,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              dmem_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              req_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wb_wen_q;
  logic [REG_AW-1:0] wb_waddr_q;
  logic [DATA_W-1:0] wb_wdata_q;
  logic              err_q;

  logic              mem_op;
  logic              timeout_hit;
  logic              wb_wen_d;
  logic [DATA_W-1:0] wb_wdata_d;

  assign mem_op      = mem_to_reg | mem_wen;
  assign timeout_hit = (state_q == WAIT) && !dmem.dmem_ack && (cnt_q == TO_LAST);
  assign wb_wen_d    = reg_wen & ~mem_wen;
  assign wb_wdata_d  = jal ? next_pc : (mem_to_reg ? dmem.dmem_rdata : alu_result);

  // A timed-out access releases the pipeline in its last cycle so the instruction is dropped.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    stall = mem_op;
        WAIT:    stall = !dmem.dmem_ack && !timeout_hit;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_wen_q   <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wb_wen_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            req_q   <= 1'b1;
            we_q    <= mem_wen;
            addr_q  <= alu_result;
            wdata_q <= rdata2;
            cnt_q   <= 8'd0;
            state_q <= WAIT;
          end else begin
            wb_wen_q   <= wb_wen_d;
            wb_waddr_q <= reg_waddr;
            wb_wdata_q <= wb_wdata_d;
          end
        end
        WAIT: begin
          if (dmem.dmem_ack) begin
            req_q      <= 1'b0;
            wb_wen_q   <= wb_wen_d;
            wb_waddr_q <= reg_waddr;
            wb_wdata_q <= wb_wdata_d;
            state_q    <= IDLE;
          end else if (cnt_q == TO_LAST) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign wb_wen          = wb_wen_q;
  assign wb_waddr        = wb_waddr_q;
  assign wb_wdata        = wb_wdata_q;
  assign dmem_err        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with an instruction-level reference model
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_result, rdata2, next_pc;
  logic        mem_to_reg, mem_wen, reg_wen, jal;
  logic [3:0]  reg_waddr;
  logic        stall, wb_wen, dmem_err;
  logic [3:0]  wb_waddr;
  logic [15:0] wb_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit err_model = 1'b0;

  always #5 clk = ~clk;

  mem_stage_if dmem_bus ();

  mem_stage #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_result (alu_result),
    .rdata2     (rdata2),
    .mem_to_reg (mem_to_reg),
    .mem_wen    (mem_wen),
    .reg_wen    (reg_wen),
    .reg_waddr  (reg_waddr),
    .jal        (jal),
    .next_pc    (next_pc),
    .dmem       (dmem_bus),
    .stall      (stall),
    .wb_wen     (wb_wen),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .dmem_err   (dmem_err)
  );

  typedef struct {
    logic [15:0] alu, rd2, npc, rdata;
    logic        m2r, mwen, rwen, jal;
    logic [3:0]  waddr;
  } instr_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic instr_t nop();
    instr_t r;
    r.alu = '0; r.rd2 = '0; r.npc = '0; r.rdata = '0;
    r.m2r = 1'b0; r.mwen = 1'b0; r.rwen = 1'b0; r.jal = 1'b0; r.waddr = '0;
    return r;
  endfunction

  task automatic drive(input instr_t in);
    alu_result          = in.alu;
    rdata2              = in.rd2;
    next_pc             = in.npc;
    mem_to_reg          = in.m2r;
    mem_wen             = in.mwen;
    reg_wen             = in.rwen;
    jal                 = in.jal;
    reg_waddr           = in.waddr;
    dmem_bus.dmem_rdata = in.rdata;
  endtask

  // Runs one instruction to retirement; the memory answers in WAIT cycle a (a > T never answers).
  task automatic run_instr(input instr_t in, input int a, input string tag);
    int   req_cnt, stall_cnt, iter, occ;
    bit   bus_bad, bubble_bad, done, mem_op, completed, wen_e, req_now;
    logic [15:0] wd_e;
    req_cnt = 0; stall_cnt = 0; iter = 0;
    bus_bad = 0; bubble_bad = 0; done = 0;
    drive(in);
    while (!done && iter < 20) begin
      req_now = dmem_bus.dmem_req;
      dmem_bus.dmem_ack = req_now ? (req_cnt + 1 == a) : 1'($urandom_range(0, 1));
      #1;
      if (iter > 0 && wb_wen !== 1'b0) bubble_bad = 1;
      if (req_now) begin
        req_cnt++;
        if (dmem_bus.dmem_addr !== in.alu || dmem_bus.dmem_we !== in.mwen ||
            dmem_bus.dmem_wdata !== in.rd2)
          bus_bad = 1;
      end
      if (stall) stall_cnt++;
      else done = 1;
      @(posedge clk);
      @(negedge clk);
      iter++;
    end
    dmem_bus.dmem_ack = 1'b0;

    mem_op    = in.m2r | in.mwen;
    completed = !mem_op || (a <= T);
    occ       = mem_op ? ((a < T) ? a : T) : 0;
    if (!completed) err_model = 1'b1;
    wen_e = completed && in.rwen && !in.mwen;
    wd_e  = in.jal ? in.npc : (in.m2r ? in.rdata : in.alu);

    check({tag, "_retire"}, 32'(done), 32'd1);
    check({tag, "_stalls"}, stall_cnt, occ);
    check({tag, "_reqcyc"}, req_cnt, occ);
    check({tag, "_bus"}, 32'(bus_bad), 32'd0);
    check({tag, "_bubble"}, 32'(bubble_bad), 32'd0);
    check({tag, "_wb_wen"}, 32'(wb_wen), 32'(wen_e));
    if (wen_e) begin
      check({tag, "_wb_wdata"}, 32'(wb_wdata), 32'(wd_e));
      check({tag, "_wb_waddr"}, 32'(wb_waddr), 32'(in.waddr));
    end
    check({tag, "_err"}, 32'(dmem_err), 32'(err_model));
    check({tag, "_req_low"}, 32'(dmem_bus.dmem_req), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   32'(dmem_bus.dmem_req),   32'd0);
    check({tag, "_we"},    32'(dmem_bus.dmem_we),    32'd0);
    check({tag, "_addr"},  32'(dmem_bus.dmem_addr),  32'd0);
    check({tag, "_wdata"}, 32'(dmem_bus.dmem_wdata), 32'd0);
    check({tag, "_wbwen"}, 32'(wb_wen),   32'd0);
    check({tag, "_wbadr"}, 32'(wb_waddr), 32'd0);
    check({tag, "_wbdat"}, 32'(wb_wdata), 32'd0);
    check({tag, "_err"},   32'(dmem_err), 32'd0);
  endtask

  initial begin
    instr_t x;
    int     a;

    // reset with a pending load on the inputs: stall must stay low
    x = nop(); x.m2r = 1'b1; x.alu = 16'h0077;
    drive(x);
    dmem_bus.dmem_ack = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    #1 check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    dmem_bus.dmem_ack = 1'b0;
    drive(nop());
    rst = 1'b0;
    err_model = 1'b0;

    x = nop(); x.alu = 16'h1234; x.rwen = 1'b1; x.waddr = 4'd3;
    run_instr(x, 0, "alu");

    x = nop(); x.alu = 16'h0040; x.m2r = 1'b1; x.rwen = 1'b1; x.waddr = 4'd5; x.rdata = 16'hBEEF;
    run_instr(x, 4, "load");

    x = nop(); x.alu = 16'h0010; x.rd2 = 16'hA5A5; x.mwen = 1'b1; x.rwen = 1'b1; x.waddr = 4'd7;
    run_instr(x, 1, "store");

    x = nop(); x.jal = 1'b1; x.npc = 16'h0102; x.rwen = 1'b1; x.waddr = 4'd15; x.alu = 16'h5555;
    run_instr(x, 0, "jal");

    x = nop(); x.alu = 16'h0022; x.rd2 = 16'h3C3C; x.m2r = 1'b1; x.mwen = 1'b1; x.rwen = 1'b1;
    x.waddr = 4'd9; x.rdata = 16'hDEAD;
    run_instr(x, 2, "ldst");

    // back-to-back loads
    x = nop(); x.alu = 16'h0100; x.m2r = 1'b1; x.rwen = 1'b1; x.waddr = 4'd1; x.rdata = 16'h1111;
    run_instr(x, 1, "b2b0");
    x.alu = 16'h0102; x.waddr = 4'd2; x.rdata = 16'h2222;
    run_instr(x, 1, "b2b1");

    // rst in the 2nd WAIT cycle alongside ack
    x = nop(); x.alu = 16'h0080; x.m2r = 1'b1; x.rwen = 1'b1; x.waddr = 4'd6; x.rdata = 16'hCAFE;
    drive(x);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    dmem_bus.dmem_ack = 1'b1;
    #1 check("midrst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    dmem_bus.dmem_ack = 1'b0;
    drive(nop());
    rst = 1'b0;
    err_model = 1'b0;

    x = nop(); x.alu = 16'h0200; x.m2r = 1'b1; x.rwen = 1'b1; x.waddr = 4'd4; x.rdata = 16'h9999;
    run_instr(x, 99, "timeout");

    x = nop(); x.alu = 16'h0300; x.m2r = 1'b1; x.rwen = 1'b1; x.waddr = 4'd8; x.rdata = 16'h4321;
    run_instr(x, T, "ack_at_limit");

    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    err_model = 1'b0;

    for (int i = 0; i < 60; i++) begin
      x.alu   = 16'($urandom);
      x.rd2   = 16'($urandom);
      x.npc   = 16'($urandom);
      x.rdata = 16'($urandom);
      x.waddr = 4'($urandom);
      x.rwen  = 1'($urandom_range(0, 3) != 0);
      x.jal   = 1'($urandom_range(0, 4) == 0);
      x.m2r   = 1'($urandom_range(0, 2) == 0);
      x.mwen  = 1'($urandom_range(0, 3) == 0);
      a = (x.m2r | x.mwen) ? $urandom_range(1, T + 2) : 0;
      run_instr(x, a, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
